wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 31 +++
 rtl/wb_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Bundle of MEM-result, long-latency-unit and register-file write signals for wb_stage.
interface wb_stage_if;
    logic        mem_valid;
    logic [4:0]  mem_wnum;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic [1:0]  mem_ld_size;
    logic        mem_ld_signed;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        lu_valid;
    logic [4:0]  lu_wnum;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        stall_req;
    logic [4:0]  w_number;
    logic [31:0] data_in;
    logic        w_en;

    modport master (
        output mem_valid, mem_wnum, mem_result, mem_is_load, mem_ld_size,
               mem_ld_signed, mem_addr_lo, mem_rdata, lu_valid, lu_wnum, lu_data,
        input  lu_ready, stall_req, w_number, data_in, w_en
    );

    modport slave (
        input  mem_valid, mem_wnum, mem_result, mem_is_load, mem_ld_size,
               mem_ld_signed, mem_addr_lo, mem_rdata, lu_valid, lu_wnum, lu_data,
        output lu_ready, stall_req, w_number, data_in, w_en
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back arbiter: MEM result vs. one-entry long-latency holding buffer, registered RF write port.
// Optional macro WB_LOAD_EXT_EN enables sub-word load lane selection and extension.
module wb_stage #(
    parameter int LU_STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    wb_stage_if.slave  bus
);

    localparam int CNT_W = $clog2(LU_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(LU_STARVE_MAX);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        buf_wnum_q, buf_wnum_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              w_en_q, w_en_d;
    logic [4:0]        w_number_q, w_number_d;
    logic [31:0]       data_in_q, data_in_d;

    logic              stall;
    logic              lu_rdy;
    logic              mem_sel, buf_sel, lu_acc, lu_sel;
    logic [31:0]       load_data;
    logic [31:0]       mem_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == STARVE_LIM) ? c : c + CNT_W'(1);
    endfunction

`ifdef WB_LOAD_EXT_EN
    function automatic logic [31:0] load_ext(input logic [1:0]  size,
                                             input logic        sgn,
                                             input logic [1:0]  lo,
                                             input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign load_data = load_ext(bus.mem_ld_size, bus.mem_ld_signed, bus.mem_addr_lo, bus.mem_rdata);
`else
    logic unused_ld_cfg;
    assign unused_ld_cfg = ^{bus.mem_ld_size, bus.mem_ld_signed, bus.mem_addr_lo};
    assign load_data     = bus.mem_rdata;
`endif

    assign mem_data = bus.mem_is_load ? load_data : bus.mem_result;

    // Starved held result pre-empts MEM; upstream re-presents the MEM slot.
    assign stall  = (state_q == FULL) && (cnt_q == STARVE_LIM);
    assign lu_rdy = (state_q == EMPTY);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_wnum_d = buf_wnum_q;
        buf_data_d = buf_data_q;
        w_en_d     = 1'b0;
        w_number_d = w_number_q;
        data_in_d  = data_in_q;

        mem_sel = !stall && bus.mem_valid && (bus.mem_wnum != 5'd0);
        buf_sel = (state_q == FULL) && !mem_sel;
        lu_acc  = bus.lu_valid && lu_rdy;
        lu_sel  = lu_acc && (bus.lu_wnum != 5'd0) && !mem_sel && !buf_sel;

        if (mem_sel) begin
            w_en_d     = 1'b1;
            w_number_d = bus.mem_wnum;
            data_in_d  = mem_data;
        end else if (buf_sel) begin
            w_en_d     = 1'b1;
            w_number_d = buf_wnum_q;
            data_in_d  = buf_data_q;
        end else if (lu_sel) begin
            w_en_d     = 1'b1;
            w_number_d = bus.lu_wnum;
            data_in_d  = bus.lu_data;
        end

        // A zero-destination lu result is consumed but never parked.
        if (buf_sel) begin
            state_d = EMPTY;
        end else if (lu_acc && (bus.lu_wnum != 5'd0) && !lu_sel) begin
            state_d    = FULL;
            buf_wnum_d = bus.lu_wnum;
            buf_data_d = bus.lu_data;
        end

        cnt_d = ((state_q == FULL) && !buf_sel) ? sat_inc(cnt_q) : '0;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= EMPTY;
            cnt_q      <= '0;
            w_en_q     <= 1'b0;
            w_number_q <= 5'd0;
            data_in_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_en_q     <= w_en_d;
            w_number_q <= w_number_d;
            data_in_q  <= data_in_d;
        end
    end

    // Held payload is only meaningful while FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_wnum_q <= buf_wnum_d;
        buf_data_q <= buf_data_d;
    end

    assign bus.lu_ready  = lu_rdy;
    assign bus.stall_req = stall;
    assign bus.w_en      = w_en_q;
    assign bus.w_number  = w_number_q;
    assign bus.data_in   = data_in_q;

endmodule
